wasm_run_ctrl: RTL

//  Run sequencer for the WASM core. Streams a bytecode program from a host into the instruction BRAM,

---
 rtl/wasm_run_ctrl_pkg.sv | 33 +++
 rtl/wasm_run_wdog.sv | 36 +++
 rtl/wasm_run_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/wasm_run_ctrl_pkg.sv
// Shared types for the WASM run sequencer: FSM states, status codes and default widths.
// Also holds a small helper that names the states which may accept a new load command.
package wasm_run_ctrl_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 8;
    localparam int TO_W_DEF    = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_e;

    typedef enum logic [2:0] {
        ST_NONE      = 3'd0,
        ST_OK        = 3'd1,
        ST_INSTR_ERR = 3'd2,
        ST_STACK_OVF = 3'd3,
        ST_TIMEOUT   = 3'd4,
        ST_ABORTED   = 3'd5,
        ST_BAD_LEN   = 3'd6
    } status_e;

    // States from which a new program load may be started.
    function automatic logic is_settled(state_e s);
        return (s == S_IDLE) || (s == S_READY) || (s == S_DONE) || (s == S_FAULT);
    endfunction

endpackage

// File: rtl/wasm_run_wdog.sv
// Run watchdog: counts RUN cycles (saturating), holds the limit sampled at run start,
// and flags expiry when a non-zero limit equals the current count.
module wasm_run_wdog
    import wasm_run_ctrl_pkg::*;
#(
    parameter int TO_W = TO_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TO_W-1:0] limit,
    input  logic            active,
    input  logic            stop,
    output logic [31:0]     count,
    output logic            expired
);

    logic [TO_W-1:0] limit_q;

    // NOTE: clocked state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_q <= '0;
            count   <= '0;
        end else if (start) begin
            limit_q <= limit;
            count   <= '0;
        end else if (active && !stop && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

    // The exit cycle does not advance the count, so it reports the limit exactly.
    assign expired = active && (limit_q != '0) && (count == 32'(limit_q));

endmodule

// File: rtl/wasm_run_ctrl.sv
// Run sequencer for the WASM core: streams a program into instruction BRAM, owns the core
// reset, supervises the run (finish/error/stack/watchdog/abort) and latches a status code.
module wasm_run_ctrl
    import wasm_run_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load_start,
    input  logic [ADDR_W:0]    i_load_len,
    input  logic               i_ld_valid,
    output logic               o_ld_ready,
    input  logic [INSTR_W-1:0] i_ld_data,
    output logic               o_bram_we,
    output logic [ADDR_W-1:0]  o_bram_addr,
    output logic [INSTR_W-1:0] o_bram_wdata,
    input  logic               i_run,
    input  logic               i_abort,
    input  logic [TO_W-1:0]    i_timeout,
    output logic               o_core_rst_n,
    input  logic               i_instr_finish,
    input  logic               i_instr_error,
    input  logic               i_stack_full,
    output logic               o_busy,
    output logic               o_done,
    output logic [2:0]         o_status,
    output logic [31:0]        o_cycle_count
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    status_e             status_q;
    status_e             run_code;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   last_q;
    logic                prog_valid_q;
    logic                enter_term;
    logic                beat, last_beat, len_bad;
    logic                load_go, run_go, run_exit, expired, in_run;

    assign in_run    = (state_q == S_RUN);
    assign beat      = i_ld_valid && o_ld_ready;
    assign last_beat = beat && (cnt_q == last_q);
    assign len_bad   = (i_load_len == '0) || (i_load_len > DEPTH);
    assign load_go   = is_settled(state_q) && i_load_start;
    assign run_go    = ((state_q == S_READY) || (state_q == S_DONE) || (state_q == S_FAULT))
                       && prog_valid_q && i_run && !i_load_start;

    // Exit reason for the current RUN cycle, highest priority first.
    always_comb begin
        run_code = ST_NONE;
        if (i_abort)             run_code = ST_ABORTED;
        else if (i_instr_error)  run_code = ST_INSTR_ERR;
        else if (i_stack_full)   run_code = ST_STACK_OVF;
        else if (i_instr_finish) run_code = ST_OK;
        else if (expired)        run_code = ST_TIMEOUT;
    end

    assign run_exit = in_run && (run_code != ST_NONE);

    wasm_run_wdog #(.TO_W(TO_W)) u_wdog (
        .clk     (i_clk),
        .rst     (i_rst),
        .start   (run_go),
        .limit   (i_timeout),
        .active  (in_run),
        .stop    (run_exit),
        .count   (o_cycle_count),
        .expired (expired)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        enter_term = 1'b0;
        case (state_q)
            S_IDLE, S_READY, S_DONE, S_FAULT: begin
                if (i_load_start) begin
                    if (len_bad) begin
                        state_d    = S_FAULT;
                        enter_term = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else if (run_go) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                if (i_abort) begin
                    state_d    = S_FAULT;
                    enter_term = 1'b1;
                end else if (last_beat) begin
                    state_d = S_READY;
                end
            end
            S_RUN: begin
                if (run_exit) begin
                    state_d    = (run_code == ST_OK) ? S_DONE : S_FAULT;
                    enter_term = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_ld_ready   = 1'b0;
        o_busy       = 1'b0;
        o_core_rst_n = 1'b0;
        case (state_q)
            S_LOAD: begin
                o_ld_ready = 1'b1;
                o_busy     = 1'b1;
            end
            S_RUN: begin
                o_busy       = 1'b1;
                o_core_rst_n = 1'b1;
            end
            default: ;
        endcase
    end

    // Load counter, registered BRAM write port, program-valid flag and status latch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q        <= '0;
            last_q       <= '0;
            prog_valid_q <= 1'b0;
            status_q     <= ST_NONE;
            o_bram_we    <= 1'b0;
            o_bram_addr  <= '0;
            o_bram_wdata <= '0;
            o_done       <= 1'b0;
        end else begin
            o_done    <= enter_term;
            o_bram_we <= beat && !i_abort;
            if (beat && !i_abort) begin
                o_bram_addr  <= cnt_q;
                o_bram_wdata <= i_ld_data;
                cnt_q        <= cnt_q + 1'b1;
            end
            if (load_go) begin
                cnt_q        <= '0;
                last_q       <= ADDR_W'(i_load_len - 1'b1);
                prog_valid_q <= 1'b0;
                status_q     <= len_bad ? ST_BAD_LEN : ST_NONE;
            end
            if (state_q == S_LOAD) begin
                if (i_abort) begin
                    prog_valid_q <= 1'b0;
                    status_q     <= ST_ABORTED;
                end else if (last_beat) begin
                    prog_valid_q <= 1'b1;
                end
            end
            if (run_go)   status_q <= ST_NONE;
            if (run_exit) status_q <= run_code;
        end
    end

    assign o_status = status_q;

endmodule
